jtcop_ba0_arb: RTL

//  Arbiter and sequencer for SDRAM bank 0, the only read/write bank. It shares the bank

---
 rtl/jtcop_ba0_arb.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/jtcop_ba0_arb.sv
`default_nettype none
// ============================================================================
//  Module   : jtcop_ba0_arb
//  Brief    : SDRAM bank-0 arbiter: CPU work RAM plus three cached VRAM read ports
//  Revision : 1.0
// ============================================================================
module jtcop_ba0_arb #(
    parameter logic [21:0] CPU_OFS   = 22'h0,
    parameter logic [21:0] VR0_OFS   = 22'h10000,
    parameter logic [21:0] VR1_OFS   = 22'h14000,
    parameter logic [21:0] VR2_OFS   = 22'h18000,
    parameter int unsigned CPU_BURST = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_cs,
    input  logic        cpu_rnw,
    input  logic [16:0] cpu_addr,
    input  logic [1:0]  cpu_dsn,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ok,
    input  logic [2:0]  vr_cs,
    input  logic [12:0] vr_addr0,
    input  logic [10:0] vr_addr1,
    input  logic [10:0] vr_addr2,
    output logic [47:0] vr_data,
    output logic [2:0]  vr_ok,
    output logic [21:0] ba0_addr,
    output logic        ba_rd,
    output logic        ba_wr,
    output logic [15:0] ba0_din,
    output logic [1:0]  ba0_din_m,
    input  logic        ba_ack,
    input  logic        ba_rdy,
    input  logic [15:0] data_read
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(CPU_BURST);

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [7:0]  burst_q, burst_d;
    logic        gnt_cpu_q, gnt_cpu_d;
    logic [1:0]  gnt_port_q, gnt_port_d;
    logic [12:0] req_vaddr_q, req_vaddr_d;
    logic [16:0] req_caddr_q, req_caddr_d;
    logic        req_rnw_q, req_rnw_d;
    logic        cpu_drop_q, cpu_drop_d;
    logic [21:0] ba0_addr_q, ba0_addr_d;
    logic [15:0] ba0_din_q, ba0_din_d;
    logic [1:0]  din_m_q, din_m_d;
    logic        ba_rd_q, ba_rd_d;
    logic        ba_wr_q, ba_wr_d;
    logic [2:0]  valid_q, valid_d;
    logic [12:0] tag_q [3];
    logic [12:0] tag_d [3];
    logic [15:0] vdata_q [3];
    logic [15:0] vdata_d [3];
    logic [2:0]  vr_ok_q, vr_ok_d;
    logic        done_valid_q, done_valid_d;
    logic [16:0] done_addr_q, done_addr_d;
    logic        done_rnw_q, done_rnw_d;
    logic [15:0] cpu_dout_q, cpu_dout_d;

    logic [12:0] vaddr [3];
    logic [2:0]  vhit, vpend;
    logic        done_match, cpu_pend, cpu_win;
    logic [1:0]  p0, p1, p2, vsel;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [21:0] vr_map(input logic [1:0] n, input logic [12:0] a);
        case (n)
            2'd0:    return VR0_OFS + {9'd0, a};
            2'd1:    return VR1_OFS + {9'd0, a};
            default: return VR2_OFS + {9'd0, a};
        endcase
    endfunction

    assign vaddr[0] = vr_addr0;
    assign vaddr[1] = {2'd0, vr_addr1};
    assign vaddr[2] = {2'd0, vr_addr2};

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            vhit[n] = valid_q[n] && (tag_q[n] == vaddr[n]);
        end
        vpend      = vr_cs & ~vhit;
        done_match = done_valid_q && (done_addr_q == cpu_addr) && (done_rnw_q == cpu_rnw);
        cpu_pend   = cpu_cs && !done_match;
        cpu_win    = cpu_pend && ((vpend == 3'd0) || (burst_q < BURST_MAX));
        // Round-robin search starting at the pointer
        p0 = rr_q;
        p1 = rr_next(p0);
        p2 = rr_next(p1);
        if (vpend[p0])      vsel = p0;
        else if (vpend[p1]) vsel = p1;
        else                vsel = p2;
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        burst_d      = burst_q;
        gnt_cpu_d    = gnt_cpu_q;
        gnt_port_d   = gnt_port_q;
        req_vaddr_d  = req_vaddr_q;
        req_caddr_d  = req_caddr_q;
        req_rnw_d    = req_rnw_q;
        cpu_drop_d   = cpu_drop_q;
        ba0_addr_d   = ba0_addr_q;
        ba0_din_d    = ba0_din_q;
        din_m_d      = din_m_q;
        ba_rd_d      = ba_rd_q;
        ba_wr_d      = ba_wr_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        vdata_d      = vdata_q;
        done_valid_d = done_valid_q;
        done_addr_d  = done_addr_q;
        done_rnw_d   = done_rnw_q;
        cpu_dout_d   = cpu_dout_q;

        // A done tag only survives while cs stays high
        if (!cpu_cs) done_valid_d = 1'b0;
        if ((state_q != IDLE) && gnt_cpu_q && !cpu_cs) cpu_drop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (cpu_win) begin
                    state_d     = REQ;
                    gnt_cpu_d   = 1'b1;
                    cpu_drop_d  = 1'b0;
                    req_caddr_d = cpu_addr;
                    req_rnw_d   = cpu_rnw;
                    ba0_addr_d  = CPU_OFS + {5'd0, cpu_addr};
                    ba0_din_d   = cpu_din;
                    din_m_d     = cpu_dsn;
                    ba_rd_d     = cpu_rnw;
                    ba_wr_d     = !cpu_rnw;
                    if (burst_q < BURST_MAX) burst_d = burst_q + 8'd1;
                end else if (vpend != 3'd0) begin
                    state_d     = REQ;
                    gnt_cpu_d   = 1'b0;
                    gnt_port_d  = vsel;
                    req_vaddr_d = vaddr[vsel];
                    ba0_addr_d  = vr_map(vsel, vaddr[vsel]);
                    ba_rd_d     = 1'b1;
                    ba_wr_d     = 1'b0;
                    rr_d        = rr_next(vsel);
                    burst_d     = 8'd0;
                end
            end
            REQ: begin
                if (ba_ack) begin
                    ba_rd_d = 1'b0;
                    ba_wr_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ba_rdy) begin
                    state_d = IDLE;
                    if (gnt_cpu_q) begin
                        if (req_rnw_q) cpu_dout_d = data_read;
                        if (cpu_cs && !cpu_drop_q) begin
                            done_valid_d = 1'b1;
                            done_addr_d  = req_caddr_q;
                            done_rnw_d   = req_rnw_q;
                        end
                        // Accesses are serialised, so invalidation is the whole
                        // write-versus-fill coherency story
                        if (!req_rnw_q) begin
                            for (int n = 0; n < 3; n++) begin
                                if (valid_q[n] && (vr_map(n[1:0], tag_q[n]) == ba0_addr_q))
                                    valid_d[n] = 1'b0;
                            end
                        end
                    end else begin
                        tag_d[gnt_port_q]   = req_vaddr_q;
                        vdata_d[gnt_port_q] = data_read;
                        valid_d[gnt_port_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ok is evaluated against next-cycle cache contents so a fill shows up at once
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            vr_ok_d[n] = valid_d[n] && vr_cs[n] && (tag_d[n] == vaddr[n]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rr_q         <= 2'd0;
            burst_q      <= 8'd0;
            gnt_cpu_q    <= 1'b0;
            gnt_port_q   <= 2'd0;
            req_vaddr_q  <= 13'd0;
            req_caddr_q  <= 17'd0;
            req_rnw_q    <= 1'b0;
            cpu_drop_q   <= 1'b0;
            ba0_addr_q   <= 22'd0;
            ba0_din_q    <= 16'd0;
            din_m_q      <= 2'd0;
            ba_rd_q      <= 1'b0;
            ba_wr_q      <= 1'b0;
            valid_q      <= 3'd0;
            vr_ok_q      <= 3'd0;
            done_valid_q <= 1'b0;
            done_addr_q  <= 17'd0;
            done_rnw_q   <= 1'b0;
            cpu_dout_q   <= 16'd0;
            for (int n = 0; n < 3; n++) begin
                tag_q[n]   <= 13'd0;
                vdata_q[n] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            burst_q      <= burst_d;
            gnt_cpu_q    <= gnt_cpu_d;
            gnt_port_q   <= gnt_port_d;
            req_vaddr_q  <= req_vaddr_d;
            req_caddr_q  <= req_caddr_d;
            req_rnw_q    <= req_rnw_d;
            cpu_drop_q   <= cpu_drop_d;
            ba0_addr_q   <= ba0_addr_d;
            ba0_din_q    <= ba0_din_d;
            din_m_q      <= din_m_d;
            ba_rd_q      <= ba_rd_d;
            ba_wr_q      <= ba_wr_d;
            valid_q      <= valid_d;
            vr_ok_q      <= vr_ok_d;
            done_valid_q <= done_valid_d;
            done_addr_q  <= done_addr_d;
            done_rnw_q   <= done_rnw_d;
            cpu_dout_q   <= cpu_dout_d;
            for (int n = 0; n < 3; n++) begin
                tag_q[n]   <= tag_d[n];
                vdata_q[n] <= vdata_d[n];
            end
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign cpu_ok    = cpu_cs && done_match;
    assign vr_data   = {vdata_q[2], vdata_q[1], vdata_q[0]};
    assign vr_ok     = vr_ok_q;
    assign ba0_addr  = ba0_addr_q;
    assign ba_rd     = ba_rd_q;
    assign ba_wr     = ba_wr_q;
    assign ba0_din   = ba0_din_q;
    assign ba0_din_m = din_m_q;

endmodule
`default_nettype wire
